// File: rtl/mult_div_seq.sv
// Iterative multiply/divide sequencer for the multicycle MIPS datapath.
// Multiply uses shift-add and divide uses restoring division. Each of these
// runs for WIDTH steps. A single FIX cycle then applies the sign correction
// and writes hi/lo. A zero divisor skips straight to DONE and raises div_zero.
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             RESET_in,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             op_reg;
  logic             neg_q_reg;   // product/quotient must be negated
  logic             neg_r_reg;   // remainder takes the dividend's sign
  logic [WIDTH:0]   acc_hi_reg;  // product upper half / N+1-bit partial remainder
  logic [WIDTH-1:0] acc_lo_reg;  // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opnd_reg;    // multiplicand or divisor magnitude
  logic             busy_reg, done_reg, div_zero_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic             a_neg, b_neg, div0, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, mul_t, div_shift, step_hi;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

  // Operand conditioning: magnitudes and signs are taken only in signed mode.
  always_comb begin
    a_neg  = is_signed & a[WIDTH-1];
    b_neg  = is_signed & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    div0   = op & (b == '0);
    accept = start & ((state_reg == IDLE) | (state_reg == DONE));
  end

  // One iteration step, plus the sign-corrected results written in FIX.
  always_comb begin
    mul_sum   = acc_hi_reg + {1'b0, opnd_reg};
    mul_t     = acc_lo_reg[0] ? mul_sum : acc_hi_reg;
    div_shift = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
    step_hi   = {1'b0, mul_t[WIDTH:1]};
    step_lo   = {mul_t[0], acc_lo_reg[WIDTH-1:1]};
    if (op_reg) begin
      // A borrow means the trial subtraction failed, so restore the shifted value.
      if (div_diff[WIDTH+1]) begin
        step_hi = div_shift;
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_diff[WIDTH:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
      end
    end
    prod     = {acc_hi_reg[WIDTH-1:0], acc_lo_reg};
    prod_fix = neg_q_reg ? -prod : prod;
    if (op_reg) begin
      fix_lo = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
      fix_hi = neg_r_reg ? -acc_hi_reg[WIDTH-1:0] : acc_hi_reg[WIDTH-1:0];
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge RESET_in) begin
    if (!RESET_in) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  // Next-state logic. Cancel aborts RUN/FIX, and start wins in IDLE/DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = div0 ? DONE : RUN;
      RUN:     if (cancel) state_next = IDLE;
               else if (cnt_reg == LAST) state_next = FIX;
      FIX:     state_next = cancel ? IDLE : DONE;
      DONE:    if (start) state_next = div0 ? DONE : RUN;
               else state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge clock or negedge RESET_in) begin
    if (!RESET_in) begin
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      busy_reg     <= (state_next == RUN) | (state_next == FIX);
      done_reg     <= (state_next == DONE);
      div_zero_reg <= accept & div0;
    end
  end

  // Datapath: latch operands on start, iterate in RUN, write hi/lo in FIX.
  always_ff @(posedge clock or negedge RESET_in) begin
    if (!RESET_in) begin
      cnt_reg    <= '0;
      op_reg     <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      if (accept) begin
        cnt_reg    <= '0;
        op_reg     <= op;
        neg_q_reg  <= a_neg ^ b_neg;
        neg_r_reg  <= a_neg;
        acc_hi_reg <= '0;
        acc_lo_reg <= op ? a_mag : b_mag;
        opnd_reg   <= op ? b_mag : a_mag;
      end else if (state_reg == RUN) begin
        cnt_reg    <= cnt_reg + 1'b1;
        acc_hi_reg <= step_hi;
        acc_lo_reg <= step_lo;
      end else if (state_reg == FIX && !cancel) begin
        hi_reg <= fix_hi;
        lo_reg <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq with WIDTH=32 and WIDTH=8 instances.
module tb_mult_div_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        RESET_in;
  logic        start, op, is_signed, cancel;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8, op8, sg8, cancel8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .RESET_in(RESET_in), .start(start), .op(op),
    .is_signed(is_signed), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clock(clock), .RESET_in(RESET_in), .start(start8), .op(op8),
    .is_signed(sg8), .a(a8), .b(b8), .cancel(cancel8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns at the negedge right after the start edge.
  task automatic go32(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    op = o; is_signed = s; a = x; b = y; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Count negedges from the start edge until done, bounded.
  task automatic wait32(input int l0, output int lat, output int bcnt);
    lat = l0; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clock);
      lat++;
    end
  endtask

  int lat, bc, seen;

  initial begin
    RESET_in = 1'b0; start = 0; op = 0; is_signed = 0; cancel = 0; a = 0; b = 0;
    start8 = 0; op8 = 0; sg8 = 0; cancel8 = 0; a8 = 0; b8 = 0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", div_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    repeat (2) @(negedge clock);
    RESET_in = 1'b1;

    // Unsigned multiply 7*6.
    go32(0, 0, 32'd7, 32'd6);
    wait32(1, lat, bc);
    check("mul_u_lat", lat, 34);
    check("mul_u_busy", bc, 33);
    check("mul_u_lo", lo, 32'h0000002A);
    check("mul_u_hi", hi, 32'h0);

    // Signed multiply -3*5.
    go32(0, 1, 32'hFFFFFFFD, 32'd5);
    wait32(1, lat, bc);
    check("mul_s_hi", hi, 32'hFFFFFFFF);
    check("mul_s_lo", lo, 32'hFFFFFFF1);

    // Unsigned full-range multiply.
    go32(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait32(1, lat, bc);
    check("mul_ff_hi", hi, 32'hFFFFFFFE);
    check("mul_ff_lo", lo, 32'h00000001);

    // Signed divide -7/2.
    go32(1, 1, 32'hFFFFFFF9, 32'd2);
    wait32(1, lat, bc);
    check("div_s_lat", lat, 34);
    check("div_s_lo", lo, 32'hFFFFFFFD);
    check("div_s_hi", hi, 32'hFFFFFFFF);

    // Unsigned divide 100/7.
    go32(1, 0, 32'd100, 32'd7);
    wait32(1, lat, bc);
    check("div_u_lo", lo, 32'd14);
    check("div_u_hi", hi, 32'd2);
    check("div_u_dz", div_zero, 1'b0);

    // Signed MIN / -1 wraps.
    go32(1, 1, 32'h80000000, 32'hFFFFFFFF);
    wait32(1, lat, bc);
    check("div_min_lo", lo, 32'h80000000);
    check("div_min_hi", hi, 32'h0);

    // Preload hi=0x11, lo=0x22 with 0x451 / 0x20, then divide by zero.
    go32(1, 0, 32'h451, 32'h20);
    wait32(1, lat, bc);
    check("pre_hi", hi, 32'h11);
    check("pre_lo", lo, 32'h22);
    go32(1, 0, 32'd5, 32'd0);
    check("dz_done", done, 1'b1);
    check("dz_flag", div_zero, 1'b1);
    check("dz_busy", busy, 1'b0);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);
    @(negedge clock);
    check("dz_done_end", done, 1'b0);
    check("dz_flag_end", div_zero, 1'b0);
    check("dz_no_run", busy, 1'b0);

    // Start re-pulsed mid-RUN with other operands is ignored.
    go32(0, 0, 32'd7, 32'd6);
    repeat (4) @(negedge clock);
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait32(6, lat, bc);
    check("restart_lat", lat, 34);
    check("restart_lo", lo, 32'h0000002A);

    // Cancel at step 10: back to IDLE, no done, hi/lo retained.
    go32(0, 0, 32'd3, 32'd5);
    repeat (9) @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check("cancel_busy", busy, 1'b0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clock);
    end
    check("cancel_no_done", seen, 0);
    check("cancel_lo", lo, 32'h0000002A);
    check("cancel_hi", hi, 32'h0);

    // Asynchronous reset mid-operation.
    go32(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(negedge clock);
    #2 RESET_in = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_lo", lo, 32'h0);
    check("arst_hi", hi, 32'h0);
    @(negedge clock);
    RESET_in = 1'b1;

    // Back-to-back: start held through DONE begins the next op immediately.
    @(negedge clock);
    op = 0; is_signed = 0; a = 32'd7; b = 32'd6; start = 1'b1;
    @(negedge clock);
    wait32(1, lat, bc);
    check("b2b_lat1", lat, 34);
    check("b2b_lo1", lo, 32'h0000002A);
    a = 32'd3; b = 32'd5;
    @(negedge clock);
    check("b2b_busy", busy, 1'b1);
    check("b2b_done_low", done, 1'b0);
    start = 1'b0;
    wait32(1, lat, bc);
    check("b2b_lat2", lat, 34);
    check("b2b_lo2", lo, 32'h0000000F);

    // WIDTH=8 signed multiply -128 * -1.
    @(negedge clock);
    op8 = 0; sg8 = 1; a8 = 8'h80; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    check("w8_mul_lat", lat, 10);
    check("w8_mul_hi", hi8, 8'h00);
    check("w8_mul_lo", lo8, 8'h80);

    // WIDTH=8 signed divide -128 / -1.
    op8 = 1; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    check("w8_div_lat", lat, 10);
    check("w8_div_lo", lo8, 8'h80);
    check("w8_div_hi", hi8, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Parametrised iterative multiply/divide sequencer for the multicycle MIPS datapath.
- Replaces fixed-width MULT/DIV handling. The control unit pulses start from its Mult/Div states and waits for done before the HI/LO write-back.
- Adds signed/unsigned modes, operand width generalisation, cancel-on-exception, and a divide-by-zero flag that the control unit routes to its exception-routine selection.

Parameters:
- WIDTH, 32, operand width N in bits; legal range 4..64.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- RESET_in  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation; sampled only in IDLE or DONE.
- op  in  1  0 = multiply, 1 = divide.
- is_signed  in  1  1 = two's-complement operands.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- cancel  in  1  synchronous abort, used on an exception during the operation.
- busy  out  1  operation in progress (RUN or FIX).
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, coincident with done, for a zero divisor.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.

Behaviour:
- Reset (RESET_in = 0, asynchronous): state = IDLE, counter = 0, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0.
- Reset asserted mid-operation: the operation is discarded and hi/lo are cleared.
- States: IDLE, RUN, FIX, DONE. All outputs are registered.
- IDLE/DONE with start = 1 at edge k:
  - Latch the magnitudes of a and b (absolute values when is_signed = 1), the result signs, op, and counter = 0.
  - Next state RUN; busy = 1 from edge k.
- Divide by zero (op = 1, b = 0) at the start edge:
  - Next state is DONE, not RUN.
  - done = 1 and div_zero = 1 for the cycle after edge k.
  - hi/lo are unchanged.
- RUN, one step per edge, WIDTH edges total:
  - Multiply: shift-add, one multiplier bit per step, into a 2N-bit accumulator.
  - Divide: restoring division, one quotient bit per step. The remainder register is N+1 bits.
  - The counter increments each step. When counter = WIDTH-1, next state is FIX.
- FIX (one edge):
  - Multiply: negate the 2N-bit product if the operand signs differ.
  - Divide: quotient is negated if the signs differ (truncation toward zero). Remainder takes the dividend's sign.
  - hi/lo are written on this edge. Next state DONE.
- DONE (one cycle): busy = 0, done = 1. The next state is IDLE, or RUN if start = 1.
- Latency: done is high for the cycle following edge k+WIDTH+1, i.e. WIDTH+2 cycles after start is sampled.
- Signed overflow, MIN / -1: lo = MIN, hi = 0 (wrap). No flag is raised.
- Unsigned mode: operands are taken raw. Product is a full 2N-bit unsigned value.
- start while busy: ignored. The operation in flight is unaffected.
- cancel = 1 in RUN or FIX:
  - Next state IDLE. No done pulse; hi/lo are unchanged.
  - cancel has priority over the FIX write-back.
- cancel in IDLE or DONE: no effect. If cancel and start are both high in IDLE or DONE, start wins.
- Outside a completion edge, hi/lo hold their last value indefinitely.

Test Plan:
- Unsigned multiply, WIDTH=32: a=7, b=6, is_signed=0, start at edge k → done high in the cycle after edge k+33; lo=0x0000002A, hi=0; busy high for 33 cycles.
- Signed multiply: a=-3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 → hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide: a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Unsigned a=100, b=7 → lo=14, hi=2. Check MIN / -1 signed → lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 with a prior op; then a=5, b=0 → done and div_zero both high the cycle after start; hi=0x11, lo=0x22 unchanged; no RUN cycles.
- Control events:
  - start re-pulsed mid-RUN → ignored, result as in the first scenario.
  - cancel at step 10 → IDLE next cycle, no done, hi/lo retain their previous values.
  - RESET_in low at step 5 → busy=0 and hi=lo=0 immediately, without a clock edge.
- Back-to-back ops and WIDTH=8 build:
  - start held high in DONE → a new op starts with no idle cycle.
  - WIDTH=8, signed a=-128, b=-1 multiply → hi=0x00, lo=0x80; latency 10 cycles.
